// File: rtl/writeback_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package writeback_pkg;

  localparam logic [3:0] R0_ADDR   = 4'd0;
  localparam int         REG_COUNT = 16;

  // One queued mul/div result. low_kill / high_kill record that a younger
  // ALU write has already superseded the low or high half.
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        low_kill;
    logic        high_kill;
  } wb_entry_t;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] a);
    logic [REG_COUNT-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_entry_queue.sv
// Circular queue of mul/div results with in-place kill-flag update.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push, push_entry      enqueue (kill rules applied to the new entry too)
//   pop                   dequeue head
//   kill_en, kill_addr    ALU write this cycle: sets kill flags on valid entries
//   head, empty, full     queue head and status
//   ent_*                 flattened per-slot valid/addr/kill for the pending mask
module wb_entry_queue
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  wb_entry_t          push_entry,
  input  logic               pop,
  input  logic               kill_en,
  input  logic [3:0]         kill_addr,
  output wb_entry_t          head,
  output logic               empty,
  output logic               full,
  output logic [DEPTH-1:0]   ent_valid,
  output logic [DEPTH*4-1:0] ent_addr,
  output logic [DEPTH-1:0]   ent_low_kill,
  output logic [DEPTH-1:0]   ent_high_kill
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  wb_entry_t        push_killed;

  // An entry pushed alongside an ALU write is older than that write, so the
  // same kill rules apply to it as it lands.
  always_comb begin
    push_killed = push_entry;
    if (kill_en) begin
      if (push_entry.addr == kill_addr) push_killed.low_kill  = 1'b1;
      if (kill_addr == R0_ADDR)         push_killed.high_kill = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PTR_W'(i))) begin
          mem[i] <= push_killed;
        end else if (kill_en && vld[i]) begin
          if (mem[i].addr == kill_addr) mem[i].low_kill  <= 1'b1;
          if (kill_addr == R0_ADDR)     mem[i].high_kill <= 1'b1;
        end
        if (pop && (rd_ptr == PTR_W'(i)))  vld[i] <= 1'b0;
        if (push && (wr_ptr == PTR_W'(i))) vld[i] <= 1'b1;
      end
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign empty     = ~|vld;
  assign full      = &vld;
  assign ent_valid = vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign ent_addr[4*g +: 4] = mem[g].addr;
    assign ent_low_kill[g]    = mem[g].low_kill;
    assign ent_high_kill[g]   = mem[g].high_kill;
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Merges ALU results and queued mul/div results into one register-file write per cycle.
// Latency: result selected in cycle N is on write_* in cycle N+1.
// Backpressure: ALU never stalled (alu_hold is advisory); md_ready = !full & !halt_sys.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   halt_sys                   freeze all state, suppress writes
//   alu_valid/addr/data        single-cycle ALU result
//   md_valid/ready/addr/data   mul/div result handshake ({high,low}, high targets R0)
//   write_en, R0_en,
//   write_address, write_data  registered register-file write port
//   pending_mask               registers with an un-killed queued write outstanding
//   alu_hold                   registered request for an ALU bubble (queue starving)
module writeback_sequencer
  import writeback_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_sys,
  input  logic        alu_valid,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [3:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        write_en,
  output logic        R0_en,
  output logic [3:0]  write_address,
  output logic [31:0] write_data,
  output logic [15:0] pending_mask,
  output logic        alu_hold
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  wb_entry_t          head;
  wb_entry_t          push_entry;
  logic               q_empty;
  logic               q_full;
  logic               push;
  logic               pop;
  logic               kill_en;
  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH*4-1:0] ent_addr;
  logic [DEPTH-1:0]   ent_low_kill;
  logic [DEPTH-1:0]   ent_high_kill;

  logic               we_n;
  logic               r0_n;
  logic [3:0]         addr_n;
  logic [31:0]        data_n;
  logic [CNT_W-1:0]   starve_cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               hold_n;

  // md_ready uses registered occupancy only: a full queue refuses even when
  // a pop happens in the same cycle.
  assign md_ready   = !q_full && !halt_sys;
  assign push       = md_valid && md_ready;
  assign kill_en    = !halt_sys && alu_valid;
  assign pop        = !halt_sys && !alu_valid && !q_empty;
  assign push_entry = '{addr: md_addr, data: md_data, low_kill: 1'b0, high_kill: 1'b0};

  wb_entry_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_entry    (push_entry),
    .pop           (pop),
    .kill_en       (kill_en),
    .kill_addr     (alu_addr),
    .head          (head),
    .empty         (q_empty),
    .full          (q_full),
    .ent_valid     (ent_valid),
    .ent_addr      (ent_addr),
    .ent_low_kill  (ent_low_kill),
    .ent_high_kill (ent_high_kill)
  );

  // Write selection: ALU first, else queue head shaped by its kill flags.
  always_comb begin
    we_n   = 1'b0;
    r0_n   = 1'b0;
    addr_n = write_address;
    data_n = write_data;
    if (kill_en) begin
      we_n   = 1'b1;
      addr_n = alu_addr;
      data_n = {16'h0000, alu_data};
    end else if (pop) begin
      case ({head.low_kill, head.high_kill})
        2'b00: begin
          we_n   = 1'b1;
          r0_n   = 1'b1;
          addr_n = head.addr;
          data_n = head.data;
        end
        2'b10: begin
          // Only the high half survives: steer it to R0 through both lanes.
          we_n   = 1'b1;
          r0_n   = 1'b1;
          addr_n = R0_ADDR;
          data_n = {head.data[31:16], head.data[31:16]};
        end
        2'b01: begin
          we_n   = 1'b1;
          addr_n = head.addr;
          data_n = {16'h0000, head.data[15:0]};
        end
        default: begin
          // Both halves superseded: entry is dropped without a write.
        end
      endcase
    end
  end

  // Starvation counter: head waiting without a pop; saturates at CNT_MAX.
  always_comb begin
    cnt_n  = starve_cnt;
    hold_n = alu_hold;
    if (!halt_sys) begin
      hold_n = (starve_cnt == CNT_MAX) && !pop;
      if (pop || q_empty)          cnt_n = '0;
      else if (starve_cnt != CNT_MAX) cnt_n = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en      <= 1'b0;
      R0_en         <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      starve_cnt    <= '0;
      alu_hold      <= 1'b0;
    end else begin
      write_en      <= we_n;
      R0_en         <= r0_n;
      write_address <= addr_n;
      write_data    <= data_n;
      starve_cnt    <= cnt_n;
      alu_hold      <= hold_n;
    end
  end

  // A killed low half no longer targets its register; an un-killed high
  // half always targets R0.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (!ent_low_kill[i])  pending_mask = pending_mask | onehot(ent_addr[4*i +: 4]);
        if (!ent_high_kill[i]) pending_mask[R0_ADDR] = 1'b1;
      end
    end
  end

endmodule
